program_counter_unit: RTL and testbench

//  Parametrised next-generation program counter for the processor fetch stage.

---
 rtl/pc_pkg.sv | 36 +++
 rtl/pc_return_stack.sv | 58 +++++
 rtl/program_counter_unit.sv | 106 ++++++++++
 tb/tb_program_counter_unit.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Package shared by the program counter and the decode stage.
//   pc_sel_e    : next-PC source selected for one clock edge
//   pc_resolve  : priority resolve of the raw control strobes
//   ring_next / ring_prev : modular index helpers for the return-address ring
package pc_pkg;

  typedef enum logic [2:0] {
    PC_HOLD,
    PC_RET,
    PC_CALL,
    PC_JUMP,
    PC_BRANCH,
    PC_SEQ
  } pc_sel_e;

  // Exactly one action per edge: stall > ret > call > jump > branch > increment.
  function automatic pc_sel_e pc_resolve(input logic stall, input logic ret,
                                         input logic call, input logic jump,
                                         input logic branch);
    if (stall)       return PC_HOLD;
    else if (ret)    return PC_RET;
    else if (call)   return PC_CALL;
    else if (jump)   return PC_JUMP;
    else if (branch) return PC_BRANCH;
    else             return PC_SEQ;
  endfunction

  function automatic int ring_next(input int idx, input int depth);
    return (idx == depth - 1) ? 0 : idx + 1;
  endfunction

  function automatic int ring_prev(input int idx, input int depth);
    return (idx == 0) ? depth - 1 : idx - 1;
  endfunction

endpackage

// File: rtl/pc_return_stack.sv
// Circular return-address stack.
// Ports:
//   clk, reset      : rising-edge clock, asynchronous active-low reset
//   push, push_data : write push_data as the new top (overwrites oldest when full)
//   pop             : discard the top entry (ignored when empty)
//   top             : current top entry (meaningless when empty)
//   depth           : live entry count, saturates at RAS_DEPTH
//   full, empty     : depth == RAS_DEPTH / depth == 0
module pc_return_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              push_data,
  output logic [ADDR_W-1:0]              top,
  output logic [$clog2(RAS_DEPTH+1)-1:0] depth,
  output logic                           full,
  output logic                           empty
);

  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  top_ptr;

  // wr_ptr is the next free slot; the ring simply wraps, so a push while full
  // lands on the oldest entry and discards it.
  assign top_ptr = PTR_W'(ring_prev(int'(wr_ptr), RAS_DEPTH));
  assign top     = mem[top_ptr];
  assign full    = (depth == CNT_W'(RAS_DEPTH));
  assign empty   = (depth == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      depth  <= '0;
    end else if (push) begin
      wr_ptr <= PTR_W'(ring_next(int'(wr_ptr), RAS_DEPTH));
      if (!full) depth <= depth + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      depth  <= depth - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/program_counter_unit.sv
// Fetch-stage program counter with sequential, branch, jump, call and return.
// Ports:
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   stall                 : hold PC, RAS and flags; fetch invalid this cycle
//   branch_en/offset      : PC-relative branch, signed offset
//   jump_en, jump_target  : absolute jump
//   call_en               : push PC+INC and jump to jump_target
//   ret_en                : pop return address into PC
//   instruction_address   : registered fetch address
//   instr_valid           : fetch address valid
//   ras_depth             : live return-stack entry count
//   ras_overflow/underflow: sticky error flags, cleared only by reset
module program_counter_unit
  import pc_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int OFF_W     = 8,
  parameter int INC       = 1,
  parameter int RESET_VEC = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           branch_en,
  input  logic signed [OFF_W-1:0]        branch_offset,
  input  logic                           jump_en,
  input  logic                           call_en,
  input  logic                           ret_en,
  input  logic [ADDR_W-1:0]              jump_target,
  output logic [ADDR_W-1:0]              instruction_address,
  output logic                           instr_valid,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_depth,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);

  // started is low only between reset release and the first edge; that edge
  // just validates RESET_VEC as the first fetch and ignores all controls.
  logic               started;
  pc_sel_e            sel_p0;
  logic [ADDR_W-1:0]  pc_next_p0;
  logic [ADDR_W-1:0]  seq_addr_p0;
  logic [ADDR_W-1:0]  branch_addr_p0;
  logic signed [ADDR_W-1:0] offset_ext_p0;
  logic [ADDR_W-1:0]  ras_top;
  logic               ras_full;
  logic               ras_empty;
  logic               ras_push;
  logic               ras_pop;

  // ---- stage p0: resolve and next-PC selection ----
  assign sel_p0         = started ? pc_resolve(stall, ret_en, call_en, jump_en, branch_en)
                                  : PC_HOLD;
  assign offset_ext_p0  = ADDR_W'(branch_offset);
  assign seq_addr_p0    = instruction_address + ADDR_W'(INC);
  assign branch_addr_p0 = instruction_address + $unsigned(offset_ext_p0);
  assign ras_push       = (sel_p0 == PC_CALL);
  assign ras_pop        = (sel_p0 == PC_RET);

  always_comb begin
    pc_next_p0 = instruction_address;
    case (sel_p0)
      PC_HOLD:   pc_next_p0 = instruction_address;
      PC_RET:    pc_next_p0 = ras_empty ? seq_addr_p0 : ras_top;
      PC_CALL:   pc_next_p0 = jump_target;
      PC_JUMP:   pc_next_p0 = jump_target;
      PC_BRANCH: pc_next_p0 = branch_addr_p0;
      PC_SEQ:    pc_next_p0 = seq_addr_p0;
      default:   pc_next_p0 = instruction_address;
    endcase
  end

  pc_return_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(seq_addr_p0),
    .top      (ras_top),
    .depth    (ras_depth),
    .full     (ras_full),
    .empty    (ras_empty)
  );

  // ---- stage p1: PC register, valid and sticky flags ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instruction_address <= ADDR_W'(RESET_VEC);
      instr_valid         <= 1'b0;
      started             <= 1'b0;
      ras_overflow        <= 1'b0;
      ras_underflow       <= 1'b0;
    end else begin
      started             <= 1'b1;
      instruction_address <= pc_next_p0;
      instr_valid         <= !(started && stall);
      if (ras_push && ras_full)  ras_overflow  <= 1'b1;
      if (ras_pop  && ras_empty) ras_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_counter_unit.sv
module tb_program_counter_unit;

  logic              clk = 1'b0;
  logic              reset;
  logic              stall, branch_en, jump_en, call_en, ret_en;
  logic signed [7:0] branch_offset;
  logic [9:0]        jump_target;
  logic [9:0]        instruction_address;
  logic              instr_valid;
  logic [2:0]        ras_depth;
  logic              ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  program_counter_unit #(
    .ADDR_W(10), .OFF_W(8), .INC(1), .RESET_VEC(0), .RAS_DEPTH(4)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .branch_en          (branch_en),
    .branch_offset      (branch_offset),
    .jump_en            (jump_en),
    .call_en            (call_en),
    .ret_en             (ret_en),
    .jump_target        (jump_target),
    .instruction_address(instruction_address),
    .instr_valid        (instr_valid),
    .ras_depth          (ras_depth),
    .ras_overflow       (ras_overflow),
    .ras_underflow      (ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              stall, br, jmp, call, ret;
    logic signed [7:0] off;
    int                tgt;
    int                addr, valid, depth, ovf, udf;
  } vec_t;

  vec_t vecs[36];

  function automatic vec_t mk(input logic s, input logic b, input int off,
                              input logic j, input logic c, input logic r,
                              input int tgt, input int addr, input int valid,
                              input int depth, input int ovf, input int udf);
    vec_t v;
    v.stall = s; v.br = b; v.off = 8'(off); v.jmp = j; v.call = c; v.ret = r;
    v.tgt = tgt; v.addr = addr; v.valid = valid; v.depth = depth;
    v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_all(input string tag, input int addr, input int valid,
                           input int depth, input int ovf, input int udf);
    check({tag, " addr"},  int'(instruction_address), addr);
    check({tag, " valid"}, int'(instr_valid), valid);
    check({tag, " depth"}, int'(ras_depth), depth);
    check({tag, " ovf"},   int'(ras_overflow), ovf);
    check({tag, " udf"},   int'(ras_underflow), udf);
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; branch_en = v.br; branch_offset = v.off; jump_en = v.jmp;
    call_en = v.call; ret_en = v.ret; jump_target = 10'(v.tgt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            s  b  off j  c  r  tgt  addr vld dep ovf udf
    vecs[0]  = mk(0, 0,   0, 0, 0, 0,   0,    0, 1,  0, 0, 0); // first fetch
    vecs[1]  = mk(0, 0,   0, 0, 0, 0,   0,    1, 1,  0, 0, 0);
    vecs[2]  = mk(0, 0,   0, 0, 0, 0,   0,    2, 1,  0, 0, 0);
    vecs[3]  = mk(0, 0,   0, 0, 0, 0,   0,    3, 1,  0, 0, 0);
    vecs[4]  = mk(0, 0,   0, 0, 0, 0,   0,    4, 1,  0, 0, 0);
    vecs[5]  = mk(0, 0,   0, 0, 0, 0,   0,    5, 1,  0, 0, 0);
    vecs[6]  = mk(0, 1,  -3, 0, 0, 0,   0,    2, 1,  0, 0, 0); // 5-3
    vecs[7]  = mk(0, 1,   7, 0, 0, 0,   0,    9, 1,  0, 0, 0); // 2+7
    vecs[8]  = mk(0, 0,   0, 1, 0, 0,   4,    4, 1,  0, 0, 0);
    vecs[9]  = mk(0, 0,   0, 0, 1, 0, 100,  100, 1,  1, 0, 0); // push 5
    vecs[10] = mk(0, 0,   0, 0, 0, 0,   0,  101, 1,  1, 0, 0);
    vecs[11] = mk(0, 0,   0, 0, 0, 0,   0,  102, 1,  1, 0, 0);
    vecs[12] = mk(0, 0,   0, 0, 0, 1,   0,    5, 1,  0, 0, 0);
    vecs[13] = mk(0, 0,   0, 0, 1, 0, 200,  200, 1,  1, 0, 0); // push 6
    vecs[14] = mk(0, 0,   0, 0, 1, 0, 300,  300, 1,  2, 0, 0); // push 201
    vecs[15] = mk(0, 0,   0, 0, 1, 0, 400,  400, 1,  3, 0, 0); // push 301
    vecs[16] = mk(0, 0,   0, 0, 1, 0, 500,  500, 1,  4, 0, 0); // push 401
    vecs[17] = mk(0, 0,   0, 0, 1, 0, 600,  600, 1,  4, 1, 0); // push 501, drop 6
    vecs[18] = mk(0, 0,   0, 0, 0, 1,   0,  501, 1,  3, 1, 0);
    vecs[19] = mk(0, 0,   0, 0, 0, 1,   0,  401, 1,  2, 1, 0);
    vecs[20] = mk(0, 0,   0, 0, 0, 1,   0,  301, 1,  1, 1, 0);
    vecs[21] = mk(0, 0,   0, 0, 0, 1,   0,  201, 1,  0, 1, 0);
    vecs[22] = mk(0, 0,   0, 0, 0, 1,   0,  202, 1,  0, 1, 1); // underflow
    vecs[23] = mk(1, 0,   0, 1, 0, 0,  50,  202, 0,  0, 1, 1); // stall beats jump
    vecs[24] = mk(1, 0,   0, 1, 0, 0,  50,  202, 0,  0, 1, 1);
    vecs[25] = mk(0, 0,   0, 1, 0, 0,  50,   50, 1,  0, 1, 1);
    vecs[26] = mk(0, 0,   0, 0, 1, 0, 700,  700, 1,  1, 1, 1); // push 51
    vecs[27] = mk(0, 0,   0, 1, 1, 1, 800,   51, 1,  0, 1, 1); // ret wins
    vecs[28] = mk(0, 1,   5, 1, 1, 0, 900,  900, 1,  1, 1, 1); // call wins, push 52
    vecs[29] = mk(0, 1, 100, 1, 0, 0,  10,   10, 1,  1, 1, 1); // jump wins
    vecs[30] = mk(0, 1, -20, 0, 0, 0,   0, 1014, 1,  1, 1, 1); // 10-20 mod 1024
    vecs[31] = mk(0, 0,   0, 1, 0, 0,1023, 1023, 1,  1, 1, 1);
    vecs[32] = mk(0, 0,   0, 0, 0, 0,   0,    0, 1,  1, 1, 1); // wrap
    vecs[33] = mk(0, 1,  -1, 0, 0, 0,   0, 1023, 1,  1, 1, 1);
    vecs[34] = mk(0, 1,   1, 0, 0, 0,   0,    0, 1,  1, 1, 1);
    vecs[35] = mk(0, 0,   0, 0, 1, 0, 300,  300, 1,  2, 1, 1); // push 1

    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) tick();
    check_all("in_reset", 0, 0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check_all("released", 0, 0, 0, 0, 0);

    for (int i = 0; i < 36; i++) begin
      drive(vecs[i]);
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].valid,
                vecs[i].depth, vecs[i].ovf, vecs[i].udf);
    end

    // Asynchronous reset between edges, mid call chain.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    jump_en = 1'b1;
    jump_target = 10'd77;
    tick();
    check_all("post_rst_first", 0, 1, 0, 0, 0); // jump ignored on first edge
    tick();
    check_all("post_rst_jump", 77, 1, 0, 0, 0);
    jump_en = 1'b0;
    ret_en = 1'b1;
    tick();
    check_all("post_rst_udf", 78, 1, 0, 0, 1);
    ret_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
